// File: rtl/lsu_bus_master_pkg.sv
// Shared definitions for the load/store bus master.
//   - bus geometry (address/data width, func3 width, lane count)
//   - RISC-V func3 encodings used by loads and stores
//   - FSM state encoding shared by the top level
package lsu_bus_master_pkg;

    localparam int AddrWidth  = 32;
    localparam int DataWidth  = 32;
    localparam int Func3Width = 3;
    localparam int NumLanes   = 4;

    localparam logic [Func3Width-1:0] F3_B  = 3'd0;
    localparam logic [Func3Width-1:0] F3_H  = 3'd1;
    localparam logic [Func3Width-1:0] F3_W  = 3'd2;
    localparam logic [Func3Width-1:0] F3_BU = 3'd4;
    localparam logic [Func3Width-1:0] F3_HU = 3'd5;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ    = 2'd1,
        WAIT_R = 2'd2,
        DONE   = 2'd3
    } lsu_state_e;

    // True for func3 codes that a store may legally use (sb/sh/sw).
    function automatic logic is_store_func3(input logic [Func3Width-1:0] f3);
        return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    endfunction

endpackage

// File: rtl/lsu_bus_master_lane_align.sv
// Combinational byte-lane steering for the load/store bus master.
//   func3     : access size / signedness (RISC-V encoding)
//   off       : byte offset within the word (addr[1:0])
//   we        : 1 for a store, 0 for a load
//   wdata     : right-justified store data
//   rdata     : raw word returned by memory
//   strobe    : byte-lane enables for a store
//   lane_data : store data replicated onto the addressed lanes
//   load_data : rdata shifted down by the offset and sign/zero extended
//   illegal   : unsupported func3 or misaligned access
module lsu_lane_align (
    input  logic [2:0]  func3,
    input  logic [1:0]  off,
    input  logic        we,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  strobe,
    output logic [31:0] lane_data,
    output logic [31:0] load_data,
    output logic        illegal
);
    import lsu_bus_master_pkg::*;

    logic [NumLanes-1:0][7:0] lanes;
    logic [31:0]              shifted;

    // Each lane picks the store byte it carries: the low byte for sb,
    // alternating half bytes for sh, its own byte for sw.
    generate
        for (genvar gi = 0; gi < NumLanes; gi++) begin : g_lane
            assign lanes[gi] = (func3 == F3_B) ? wdata[7:0] :
                               (func3 == F3_H) ? wdata[8*(gi%2) +: 8] :
                                                 wdata[8*gi +: 8];
        end
    endgenerate

    assign lane_data = lanes;
    assign shifted   = rdata >> {off, 3'b000};

    always_comb begin
        strobe  = 4'b0000;
        illegal = 1'b0;
        case (func3)
            F3_B: strobe = 4'b0001 << off;
            F3_H: begin
                strobe  = 4'b0011 << off;
                illegal = off[0];
            end
            F3_W: begin
                strobe  = 4'b1111;
                illegal = (off != 2'b00);
            end
            F3_BU:   illegal = 1'b0;
            F3_HU:   illegal = off[0];
            default: illegal = 1'b1;
        endcase
        // Unsigned variants exist only for loads.
        if (we && !is_store_func3(func3)) begin
            illegal = 1'b1;
        end
    end

    always_comb begin
        load_data = shifted;
        case (func3)
            F3_B:    load_data = {{24{shifted[7]}},  shifted[7:0]};
            F3_H:    load_data = {{16{shifted[15]}}, shifted[15:0]};
            F3_BU:   load_data = {24'h000000, shifted[7:0]};
            F3_HU:   load_data = {16'h0000,   shifted[15:0]};
            default: load_data = shifted;
        endcase
    end

endmodule

// File: rtl/lsu_bus_master.sv
// Load/store bus master for the MEM stage.
// Turns a one-cycle load/store request from the pipeline into a
// req/ready + rvalid transaction on a word-addressed data bus, stalling
// the pipeline until it completes.
//   clk, reset        : clock, synchronous active-high reset
//   memReadEnable     : load request        memWriteEnable : store request
//   func3, memAddr    : access type, byte address
//   memWriteData      : right-justified store data
//   stall             : hold the pipeline
//   done              : one-cycle completion pulse
//   memReadData       : extended load result, held until the next load
//   misalign, busErr  : exception / timeout pulses, qualified by done
//   busReq, busWe     : request valid, write request
//   busAddr, busWstrb, busWdata : word address, lane enables, lane data
//   busReady, busRvalid, busRdata : responder handshake and read word
module lsu_bus_master #(
    parameter int AddrWidth = 32,
    parameter int DataWidth = 32,
    parameter int TIMEOUT   = 255
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 memReadEnable,
    input  logic                 memWriteEnable,
    input  logic [2:0]           func3,
    input  logic [AddrWidth-1:0] memAddr,
    input  logic [DataWidth-1:0] memWriteData,
    output logic                 stall,
    output logic                 done,
    output logic [DataWidth-1:0] memReadData,
    output logic                 misalign,
    output logic                 busErr,
    output logic                 busReq,
    output logic                 busWe,
    output logic [AddrWidth-1:0] busAddr,
    output logic [3:0]           busWstrb,
    output logic [DataWidth-1:0] busWdata,
    input  logic                 busReady,
    input  logic                 busRvalid,
    input  logic [DataWidth-1:0] busRdata
);
    import lsu_bus_master_pkg::*;

    localparam int                CntW    = $clog2(TIMEOUT + 1);
    localparam logic [CntW-1:0]   CntLast = CntW'(TIMEOUT - 1);

    lsu_state_e           state_reg, state_next;
    logic [CntW-1:0]      cnt_reg;
    logic [AddrWidth-1:0] addr_reg;
    logic [3:0]           strobe_reg;
    logic [DataWidth-1:0] wdata_reg;
    logic [DataWidth-1:0] rdata_reg;
    logic [1:0]           off_reg;
    logic [2:0]           func3_reg;
    logic                 we_reg;
    logic                 mis_reg;
    logic                 err_reg;

    logic                 start;
    logic                 illegal_any;
    logic                 capture;
    logic                 timeout_hit;

    logic [2:0]           align_func3;
    logic [1:0]           align_off;
    logic                 align_we;
    logic [3:0]           align_strobe;
    logic [31:0]          align_lane_data;
    logic [31:0]          align_load_data;
    logic                 align_illegal;

    assign start = (memReadEnable | memWriteEnable) && (state_reg == IDLE);

    // In IDLE the aligner classifies the incoming request; afterwards it
    // sees the latched access so it can extend the returned read word.
    assign align_func3 = (state_reg == IDLE) ? func3          : func3_reg;
    assign align_off   = (state_reg == IDLE) ? memAddr[1:0]   : off_reg;
    assign align_we    = (state_reg == IDLE) ? memWriteEnable : we_reg;

    lsu_lane_align u_align (
        .func3     (align_func3),
        .off       (align_off),
        .we        (align_we),
        .wdata     (memWriteData),
        .rdata     (busRdata),
        .strobe    (align_strobe),
        .lane_data (align_lane_data),
        .load_data (align_load_data),
        .illegal   (align_illegal)
    );

    assign illegal_any = align_illegal | (memReadEnable & memWriteEnable);

    // Next-state and handshake outputs. A response that arrives in the
    // last counted cycle still completes normally rather than timing out.
    always_comb begin
        state_next  = state_reg;
        busReq      = 1'b0;
        busWe       = 1'b0;
        done        = 1'b0;
        capture     = 1'b0;
        timeout_hit = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next = illegal_any ? DONE : REQ;
                end
            end
            REQ: begin
                busReq = 1'b1;
                busWe  = we_reg;
                if (busReady) begin
                    if (we_reg) begin
                        state_next = DONE;
                    end else if (busRvalid) begin
                        capture    = 1'b1;
                        state_next = DONE;
                    end else begin
                        state_next = WAIT_R;
                    end
                end else if (cnt_reg == CntLast) begin
                    timeout_hit = 1'b1;
                    state_next  = DONE;
                end
            end
            WAIT_R: begin
                if (busRvalid) begin
                    capture    = 1'b1;
                    state_next = DONE;
                end else if (cnt_reg == CntLast) begin
                    timeout_hit = 1'b1;
                    state_next  = DONE;
                end
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg  <= IDLE;
            cnt_reg    <= '0;
            addr_reg   <= '0;
            strobe_reg <= '0;
            wdata_reg  <= '0;
            rdata_reg  <= '0;
            off_reg    <= '0;
            func3_reg  <= '0;
            we_reg     <= 1'b0;
            mis_reg    <= 1'b0;
            err_reg    <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (start) begin
                cnt_reg <= '0;
                mis_reg <= illegal_any;
                err_reg <= 1'b0;
                // Illegal requests never reach the bus, so leave the
                // request registers untouched for them.
                if (!illegal_any) begin
                    addr_reg   <= {memAddr[AddrWidth-1:2], 2'b00};
                    strobe_reg <= memWriteEnable ? align_strobe : 4'b0000;
                    wdata_reg  <= memWriteEnable ? align_lane_data : '0;
                    off_reg    <= memAddr[1:0];
                    func3_reg  <= func3;
                    we_reg     <= memWriteEnable;
                end
            end else if (state_reg == REQ || state_reg == WAIT_R) begin
                cnt_reg <= cnt_reg + 1'b1;
                if (timeout_hit) begin
                    err_reg <= 1'b1;
                end
            end
            if (capture) begin
                rdata_reg <= align_load_data;
            end
        end
    end

    assign stall       = start | (state_reg == REQ) | (state_reg == WAIT_R);
    assign misalign    = done & mis_reg;
    assign busErr      = done & err_reg;
    assign memReadData = rdata_reg;
    assign busAddr     = addr_reg;
    assign busWstrb    = strobe_reg;
    assign busWdata    = wdata_reg;

endmodule
